// File: rtl/jtopl_wrseq.sv
// Register-write sequencer for the OPL register file.
// Host (register, value) pairs are queued in a FIFO and replayed as an
// address-port write, an AW-tick settle wait, a data-port write and a
// DW-tick settle wait. Waits count cen ticks only. The address phase is
// skipped when the target register is already selected.

module jtopl_wrseq #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             req_reg,
  input  logic [7:0]             req_val,
  input  logic                   flush,
  output logic                   opl_write,
  output logic                   opl_addr,
  output logic [7:0]             opl_din,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned LW      = PW + 1;
  localparam int unsigned MaxWait = (AW > DW) ? AW : DW;
  localparam int unsigned CW      = (MaxWait < 2) ? 1 : $clog2(MaxWait + 1);

  typedef enum logic [2:0] {StIdle, StAddr, StAwait, StData, StDwait} state_e;

  // FIFO storage and bookkeeping
  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          full, empty, push, pop;
  logic [15:0]   head;

  // Sequencer state
  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [15:0]   hold_q;
  logic [7:0]    last_sel_q;
  logic          sel_ok_q;
  logic          load_hold, set_sel;
  logic          addr_q;
  logic [7:0]    din_q;

  assign full      = (cnt_q == LW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign req_ready = ~full & ~rst;
  // A push coinciding with flush is dropped along with the queue contents.
  assign push      = req_valid & req_ready & ~flush;
  assign head      = mem_q[rd_ptr_q];
  assign level     = cnt_q;
  assign busy      = ~empty | (state_q != StIdle);

  // Occupancy next-state; push and pop together leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + LW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - LW'(1);
    end
  end

  // FIFO pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_reg, req_val};
  end

  // Sequencer next-state: pop, strobe phases and cen-tick waits.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    pop       = 1'b0;
    load_hold = 1'b0;
    set_sel   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !flush) begin
          pop       = 1'b1;
          load_hold = 1'b1;
          state_d   = (sel_ok_q && head[15:8] == last_sel_q) ? StData : StAddr;
        end
      end
      StAddr: begin
        set_sel = 1'b1;
        wcnt_d  = CW'(AW);
        state_d = StAwait;
      end
      StAwait: begin
        // A zero count still spends one clk here so strobes never abut.
        if (wcnt_q == '0) begin
          state_d = StData;
        end else if (cen) begin
          wcnt_d = wcnt_q - CW'(1);
          if (wcnt_q == CW'(1)) state_d = StData;
        end
      end
      StData: begin
        wcnt_d  = CW'(DW);
        state_d = StDwait;
      end
      StDwait: begin
        if (wcnt_q == '0) begin
          state_d = StIdle;
        end else if (cen) begin
          wcnt_d = wcnt_q - CW'(1);
          if (wcnt_q == CW'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Register-file bus: strobe only in the two write phases, hold bus otherwise.
  always_comb begin
    opl_write = 1'b0;
    opl_addr  = addr_q;
    opl_din   = din_q;
    if (state_q == StAddr) begin
      opl_write = 1'b1;
      opl_addr  = 1'b0;
      opl_din   = hold_q[15:8];
    end else if (state_q == StData) begin
      opl_write = 1'b1;
      opl_addr  = 1'b1;
      opl_din   = hold_q[7:0];
    end
  end

  // Sequencer registers, holding register, selection cache and bus hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wcnt_q     <= '0;
      hold_q     <= '0;
      last_sel_q <= '0;
      sel_ok_q   <= 1'b0;
      addr_q     <= 1'b0;
      din_q      <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (load_hold) hold_q <= head;
      if (set_sel) begin
        last_sel_q <= hold_q[15:8];
        sel_ok_q   <= 1'b1;
      end
      if (opl_write) begin
        addr_q <= opl_addr;
        din_q  <= opl_din;
      end
    end
  end

endmodule

// File: tb/tb_jtopl_wrseq.sv
// Self-checking bench for jtopl_wrseq: a transaction-level reference model
// (pair queue plus a list of pending strobe/wait actions) is stepped on every
// clk edge and compared with the DUT outputs on every falling edge.

module tb_jtopl_wrseq;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 24;

  logic       clk = 1'b0;
  logic       rst, cen, req_valid, req_ready, flush;
  logic [7:0] req_reg, req_val;
  logic       opl_write, opl_addr, busy;
  logic [7:0] opl_din;
  logic [$clog2(DEPTH):0] level;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtopl_wrseq #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_reg  (req_reg),
    .req_val  (req_val),
    .flush    (flush),
    .opl_write(opl_write),
    .opl_addr (opl_addr),
    .opl_din  (opl_din),
    .busy     (busy),
    .level    (level)
  );

  // Reference model: kind 0 = address strobe, 1 = data strobe, 2 = wait.
  typedef struct {
    int kind;
    int rem;
  } act_t;

  logic [15:0] mq[$];
  act_t        acts[$];
  logic [7:0]  m_reg, m_val, m_last_sel, m_din;
  logic        m_sel_ok, m_addr;

  // Strobe bookkeeping for the directed scenarios.
  int         n_astb, n_dstb, max_level;
  logic [7:0] last_adin, last_ddin;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    acts.delete();
    m_reg      = '0;
    m_val      = '0;
    m_last_sel = '0;
    m_din      = '0;
    m_sel_ok   = 1'b0;
    m_addr     = 1'b0;
  endfunction

  function automatic void add_act(int k, int r);
    act_t a;
    a.kind = k;
    a.rem  = r;
    acts.push_back(a);
  endfunction

  // One clk edge of the model, using the inputs held during the cycle.
  function automatic void model_step();
    logic        do_push, do_pop, idle;
    logic [15:0] h;
    if (rst) begin
      model_reset();
      return;
    end
    idle    = (acts.size() == 0);
    do_push = req_valid && (mq.size() < DEPTH) && !flush;
    do_pop  = idle && (mq.size() > 0) && !flush;
    if (!idle) begin
      if (acts[0].kind == 0) begin
        m_addr     = 1'b0;
        m_din      = m_reg;
        m_last_sel = m_reg;
        m_sel_ok   = 1'b1;
        void'(acts.pop_front());
      end else if (acts[0].kind == 1) begin
        m_addr = 1'b1;
        m_din  = m_val;
        void'(acts.pop_front());
      end else if (acts[0].rem == 0) begin
        void'(acts.pop_front());
      end else if (cen) begin
        acts[0].rem = acts[0].rem - 1;
        if (acts[0].rem == 0) void'(acts.pop_front());
      end
    end
    if (do_pop) begin
      h     = mq.pop_front();
      m_reg = h[15:8];
      m_val = h[7:0];
      if (!(m_sel_ok && m_reg == m_last_sel)) begin
        add_act(0, 0);
        add_act(2, AW);
      end
      add_act(1, 0);
      add_act(2, DW);
    end
    if (flush) mq.delete();
    else if (do_push) mq.push_back({req_reg, req_val});
  endfunction

  function automatic void compare_all();
    logic       e_write, e_addr;
    logic [7:0] e_din;
    e_write = (acts.size() > 0) && (acts[0].kind != 2);
    e_addr  = e_write ? (acts[0].kind == 1) : m_addr;
    e_din   = e_write ? ((acts[0].kind == 0) ? m_reg : m_val) : m_din;
    check("opl_write", opl_write, e_write);
    check("opl_addr", opl_addr, e_addr);
    check("opl_din", opl_din, e_din);
    check("req_ready", req_ready, !rst && (mq.size() < DEPTH));
    check("busy", busy, (mq.size() > 0) || (acts.size() > 0));
    check("level", level, mq.size());
  endfunction

  // Advance one clk, step the model, then compare on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (opl_write && !opl_addr) begin
      n_astb++;
      last_adin = opl_din;
    end
    if (opl_write && opl_addr) begin
      n_dstb++;
      last_ddin = opl_din;
    end
    if (int'(level) > max_level) max_level = int'(level);
  endtask

  task automatic push(input logic [7:0] r, input logic [7:0] v);
    int   n;
    logic rdy;
    req_valid = 1'b1;
    req_reg   = r;
    req_val   = v;
    n         = 0;
    do begin
      rdy = req_ready;
      cycle();
      n++;
    end while (!rdy && n < 400);
    check("push_accept", rdy, 1'b1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      cycle();
      n++;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, td, tb;
    logic [7:0] ta_din, td_din;
    int n;

    rst = 1'b1; cen = 1'b0; req_valid = 1'b0; flush = 1'b0;
    req_reg = '0; req_val = '0;
    n_astb = 0; n_dstb = 0; max_level = 0; last_adin = '0; last_ddin = '0;
    model_reset();
    @(negedge clk);

    // Reset values, then ready on the first clk after rst falls.
    repeat (3) cycle();
    check("rst_ready", req_ready, 1'b0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_write", opl_write, 1'b0);
    check("rst_din", opl_din, 8'h00);
    check("rst_addr", opl_addr, 1'b0);
    rst = 1'b0;
    cycle();
    check("ready_after_rst", req_ready, 1'b1);

    // Single pair, cen on every even edge: strobe timing pinned by hand.
    ta = 0; td = 0; tb = 0; ta_din = '0; td_din = '0;
    for (int k = 1; k <= 62; k++) begin
      cen       = (k % 2 == 0);
      req_valid = (k == 1);
      req_reg   = 8'hA0;
      req_val   = 8'h41;
      cycle();
      if (opl_write && !opl_addr && ta == 0) begin ta = k; ta_din = opl_din; end
      if (opl_write && opl_addr && td == 0) begin td = k; td_din = opl_din; end
      if (!busy && tb == 0) tb = k;
    end
    req_valid = 1'b0;
    check("t_addr_strobe", ta, 2);
    check("t_addr_din", ta_din, 8'hA0);
    check("t_data_strobe", td, 10);
    check("t_data_din", td_din, 8'h41);
    check("t_busy_low", tb, 58);

    // Same register twice: second pair skips the address phase.
    cen = 1'b1; n_astb = 0; n_dstb = 0;
    push(8'hB0, 8'h20);
    push(8'hB0, 8'h31);
    wait_idle(400);
    check("samereg_addr_cnt", n_astb, 1);
    check("samereg_data_cnt", n_dstb, 2);
    check("samereg_last_val", last_ddin, 8'h31);

    // Nine pairs with cen stalled: queue fills to DEPTH, order preserved.
    cen = 1'b0; n_astb = 0; n_dstb = 0; max_level = 0;
    for (int i = 0; i < 9; i++) push(8'h10 + 8'(i), 8'h60 + 8'(i));
    check("fill_ready_low", req_ready, 1'b0);
    check("fill_level", level, 8);
    cen = 1'b1;
    wait_idle(2000);
    check("fill_max_level", max_level, 8);
    check("fill_addr_cnt", n_astb, 9);
    check("fill_data_cnt", n_dstb, 9);
    check("fill_last_val", last_ddin, 8'h68);

    // Flush while the first of five pairs is in its address wait.
    cen = 1'b0; n_astb = 0; n_dstb = 0;
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i), 8'h70 + 8'(i));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_level", level, 0);
    check("flush_busy", busy, 1'b1);
    cen = 1'b1;
    wait_idle(400);
    check("flush_addr_cnt", n_astb, 1);
    check("flush_data_cnt", n_dstb, 1);
    check("flush_data_val", last_ddin, 8'h70);

    // Reset during the data wait; selection cache must be forgotten.
    cen = 1'b1; n_dstb = 0;
    push(8'hC0, 8'h01);
    n = 0;
    while (n_dstb == 0 && n < 400) begin
      cycle();
      n++;
    end
    check("rst_mid_data_seen", n_dstb, 1);
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    check("midrst_write", opl_write, 1'b0);
    check("midrst_addr", opl_addr, 1'b0);
    check("midrst_din", opl_din, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_level", level, 0);
    rst = 1'b0;
    cycle();
    check("midrst_ready", req_ready, 1'b1);
    n_astb = 0; n_dstb = 0;
    push(8'hC0, 8'h02);
    wait_idle(400);
    check("midrst_addr_cnt", n_astb, 1);
    check("midrst_addr_din", last_adin, 8'hC0);
    check("midrst_data_val", last_ddin, 8'h02);

    // Randomized traffic against the model.
    for (int k = 0; k < 5000; k++) begin
      rst       = ($urandom_range(0, 399) == 0);
      flush     = ($urandom_range(0, 79) == 0);
      cen       = ($urandom_range(0, 3) != 0);
      req_valid = ($urandom_range(0, 9) < 6);
      req_reg   = 8'hA0 + 8'($urandom_range(0, 2));
      req_val   = 8'($urandom);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; req_valid = 1'b0; cen = 1'b1;
    wait_idle(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
